instr_encoder: RTL

- Inverse of the decode-stage immediate extraction. Accepts decoded instruction fields (format, opcode, registers, 64-bit immediate) over a valid/ready handshake.
- Range-checks the immediate against its field width and packs a 32-bit LEGv8 instruction word.
- Writes each good word into instruction memory at an auto-incrementing byte address.
- Used by the test/boot loader to fill imem, and as a round-trip partner to the decoder in verification.

---
 rtl/instr_encoder.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Takes a bundle of decoded LEGv8 instruction fields (format, opcode, register
// numbers, shift amount, MOVZ/MOVK halfword select and a 64-bit immediate).
// It checks that the immediate fits its field, packs a 32-bit instruction word
// and writes that word into instruction memory at an auto-incrementing byte
// address. It is the inverse of the decoder's immediate extraction. The boot
// loader uses it to fill imem, and it also serves as the decoder's round-trip
// partner.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   base_load    in IDLE: load base_addr (word aligned) into the write pointer
//   base_addr    start byte address, bits [1:0] ignored
//   in_valid     field bundle valid
//   in_ready     encoder can accept a bundle (IDLE only)
//   in_fmt       0=R 1=SHIFT 2=I 3=D 4=CB 5=B 6=IM, 7 illegal
//   in_opcode    opcode, left-aligned as instruction [31:21]
//   in_rd        Rd/Rt
//   in_rn        Rn
//   in_rm        Rm
//   in_shamt     shift amount
//   in_hw        MOVZ/MOVK halfword select
//   in_imm       immediate, two's complement
//   imem_we      one-cycle imem write strobe
//   imem_addr    imem write byte address (holds between writes)
//   imem_wdata   encoded word (holds between writes)
//   err_valid    one-cycle error pulse
//   err_code     01 immediate out of range, 10 illegal format; held until the
//                next err_valid
//   instr_count  words written since reset, saturates at 0xFFFF
//   err_clear    leaves HALT (optional feature only)
//
// Optional feature: define INSTR_ENC_HALT_ON_ERR_EN to park the FSM in HALT
// after an error until err_clear is seen. Without it, a bad bundle is dropped
// and the FSM returns to IDLE.
//
// Timing: a handshake in cycle N gives imem_we (or err_valid) in cycle N+2.
// The encoder accepts one bundle every 3 cycles.
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int unsigned WORD      = 64,
   parameter int unsigned INSTR_LEN = 32,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 base_load,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_fmt,
   input  logic [10:0]          in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rn,
   input  logic [4:0]           in_rm,
   input  logic [5:0]           in_shamt,
   input  logic [1:0]           in_hw,
   input  logic [WORD-1:0]      in_imm,
   output logic                 imem_we,
   output logic [ADDR_W-1:0]    imem_addr,
   output logic [INSTR_LEN-1:0] imem_wdata,
   output logic                 err_valid,
   output logic [1:0]           err_code,
   output logic [15:0]          instr_count,
   input  logic                 err_clear
);

   localparam logic [2:0] FmtR     = 3'd0;
   localparam logic [2:0] FmtShift = 3'd1;
   localparam logic [2:0] FmtI     = 3'd2;
   localparam logic [2:0] FmtD     = 3'd3;
   localparam logic [2:0] FmtCb    = 3'd4;
   localparam logic [2:0] FmtB     = 3'd5;
   localparam logic [2:0] FmtIm    = 3'd6;

   localparam logic [1:0] ErrRange = 2'b01;
   localparam logic [1:0] ErrFmt   = 2'b10;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCheck = 2'd1,
      StWrite = 2'd2
`ifdef INSTR_ENC_HALT_ON_ERR_EN
      ,
      StHalt  = 2'd3
`endif
   } state_e;

   state_e state_q, state_d;

   // Holding register for the accepted bundle.
   logic [2:0]      fmt_q, fmt_d;
   logic [10:0]     op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [4:0]      rn_q, rn_d;
   logic [4:0]      rm_q, rm_d;
   logic [5:0]      shamt_q, shamt_d;
   logic [1:0]      hw_q, hw_d;
   logic [WORD-1:0] imm_q, imm_d;

   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_LEN-1:0] wdata_q, wdata_d;
   logic                 err_valid_q, err_valid_d;
   logic [1:0]           err_code_q, err_code_d;
   logic [15:0]          count_q, count_d;

   // The state that follows an error.
   state_e err_next;
`ifdef INSTR_ENC_HALT_ON_ERR_EN
   assign err_next = StHalt;
`else
   assign err_next = StIdle;
   logic unused_err_clear;
   assign unused_err_clear = err_clear;
`endif

   logic [1:0] unused_base_lsbs;
   assign unused_base_lsbs = base_addr[1:0];

   // -------------------------------------------------------------------------
   // Range check. A value fits an N-bit signed field when bits [WORD-1:N-1]
   // are all zero or all one (pure sign extension).
   // -------------------------------------------------------------------------
   logic fits_i, fits_d, fits_cb, fits_b, fits_im;

   assign fits_i  = (&imm_q[WORD-1:11]) | ~(|imm_q[WORD-1:11]);
   assign fits_d  = (&imm_q[WORD-1:8])  | ~(|imm_q[WORD-1:8]);
   assign fits_cb = (&imm_q[WORD-1:18]) | ~(|imm_q[WORD-1:18]);
   assign fits_b  = (&imm_q[WORD-1:25]) | ~(|imm_q[WORD-1:25]);
   assign fits_im = ~(|imm_q[WORD-1:16]);

   logic fmt_bad;
   logic imm_ok;

   always_comb begin
      fmt_bad = 1'b0;
      imm_ok  = 1'b1;
      unique case (fmt_q)
         FmtR, FmtShift: imm_ok = 1'b1;
         FmtI:           imm_ok = fits_i;
         FmtD:           imm_ok = fits_d;
         FmtCb:          imm_ok = fits_cb;
         FmtB:           imm_ok = fits_b;
         FmtIm:          imm_ok = fits_im;
         default:        fmt_bad = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // Packing, MSB first.
   // -------------------------------------------------------------------------
   logic [INSTR_LEN-1:0] packed_word;

   always_comb begin
      packed_word = '0;
      unique case (fmt_q)
         FmtR:     packed_word = {op_q, rm_q, 6'b0, rn_q, rd_q};
         FmtShift: packed_word = {op_q, 5'b0, shamt_q, rn_q, rd_q};
         FmtI:     packed_word = {op_q[10:1], imm_q[11:0], rn_q, rd_q};
         FmtD:     packed_word = {op_q, imm_q[8:0], 2'b00, rn_q, rd_q};
         FmtCb:    packed_word = {op_q[10:3], imm_q[18:0], rd_q};
         FmtB:     packed_word = {op_q[10:5], imm_q[25:0]};
         FmtIm:    packed_word = {op_q[10:2], hw_q, imm_q[15:0], rd_q};
         default:  packed_word = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      fmt_d       = fmt_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rn_d        = rn_q;
      rm_d        = rm_q;
      shamt_d     = shamt_q;
      hw_d        = hw_q;
      imm_d       = imm_q;
      ptr_d       = ptr_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      count_d     = count_q;

      unique case (state_q)
         StIdle: begin
            // The base load wins over a coincident handshake, so the captured
            // bundle writes to the new base.
            if (base_load) begin
               ptr_d = {base_addr[ADDR_W-1:2], 2'b00};
            end
            if (in_valid) begin
               fmt_d   = in_fmt;
               op_d    = in_opcode;
               rd_d    = in_rd;
               rn_d    = in_rn;
               rm_d    = in_rm;
               shamt_d = in_shamt;
               hw_d    = in_hw;
               imm_d   = in_imm;
               state_d = StCheck;
            end
         end

         StCheck: begin
            if (fmt_bad) begin
               err_valid_d = 1'b1;
               err_code_d  = ErrFmt;
               state_d     = err_next;
            end else if (!imm_ok) begin
               err_valid_d = 1'b1;
               err_code_d  = ErrRange;
               state_d     = err_next;
            end else begin
               // The outputs are registered here so that they show up in
               // WRITE and then hold.
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = packed_word;
               state_d = StWrite;
            end
         end

         StWrite: begin
            ptr_d = ptr_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) begin
               count_d = count_q + 16'd1;
            end
            state_d = StIdle;
         end

`ifdef INSTR_ENC_HALT_ON_ERR_EN
         StHalt: begin
            if (err_clear) begin
               state_d = StIdle;
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         fmt_q       <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         rn_q        <= '0;
         rm_q        <= '0;
         shamt_q     <= '0;
         hw_q        <= '0;
         imm_q       <= '0;
         ptr_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fmt_q       <= fmt_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rn_q        <= rn_d;
         rm_q        <= rm_d;
         shamt_q     <= shamt_d;
         hw_q        <= hw_d;
         imm_q       <= imm_d;
         ptr_q       <= ptr_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         count_q     <= count_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign imem_we     = we_q;
   assign imem_addr   = addr_q;
   assign imem_wdata  = wdata_q;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign instr_count = count_q;

endmodule
